br_issue_sched: RTL and testbench

Four-entry branch reservation station and issue scheduler that sits between dispatch and the branch execution unit. It buffers branch/jump micro-ops and captures missing source operands from the common data bus. Each cycle it selects the oldest entry whose operands are both ready and drives it into a registered issue stage feeding the branch unit, which accepts one op per cycle. A misprediction flush empties the station.

---
 rtl/br_issue_sched.sv | 212 +++++++++++++++++++++
 tb/tb_br_issue_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/br_issue_sched.sv
// Branch reservation station: buffers branch/jump micro-ops, wakes operands off the CDB,
// and issues the oldest ready entry per cycle into a registered issue stage.
module br_issue_sched #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int OPSEL_W = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_flush,
    input  logic                        i_dis_vld,
    output logic                        o_dis_rdy,
    input  logic                        i_dis_is_jal,
    input  logic                        i_dis_is_jalr,
    input  logic [OPSEL_W-1:0]          i_dis_op_sel,
    input  logic                        i_dis_rs1_rdy,
    input  logic                        i_dis_rs2_rdy,
    input  logic [TAG_W-1:0]            i_dis_rs1_tag,
    input  logic [TAG_W-1:0]            i_dis_rs2_tag,
    input  logic [DATA_W-1:0]           i_dis_rs1,
    input  logic [DATA_W-1:0]           i_dis_rs2,
    input  logic [PC_W-1:0]             i_dis_pc,
    input  logic [DATA_W-1:0]           i_dis_imm,
    input  logic [PC_W-1:0]             i_dis_pred_jmpaddr,
    input  logic                        i_cdb_vld,
    input  logic [TAG_W-1:0]            i_cdb_tag,
    input  logic [DATA_W-1:0]           i_cdb_data,
    output logic                        o_is_vld,
    output logic                        o_is_jal,
    output logic                        o_is_jalr,
    output logic [OPSEL_W-1:0]          o_is_op_sel,
    output logic [DATA_W-1:0]           o_is_rs1,
    output logic [DATA_W-1:0]           o_is_rs2,
    output logic [PC_W-1:0]             o_is_pc,
    output logic [DATA_W-1:0]           o_is_imm,
    output logic [PC_W-1:0]             o_is_pred_jmpaddr,
    output logic [$clog2(ENTRIES):0]    o_cnt
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = $clog2(ENTRIES) + 1;

    // Station entries
    logic [ENTRIES-1:0] r_vld;
    logic [ENTRIES-1:0] r_rs1_rdy;
    logic [ENTRIES-1:0] r_rs2_rdy;
    logic [ENTRIES-1:0] r_jal;
    logic [ENTRIES-1:0] r_jalr;
    logic [TAG_W-1:0]   r_rs1_tag [ENTRIES];
    logic [TAG_W-1:0]   r_rs2_tag [ENTRIES];
    logic [DATA_W-1:0]  r_rs1_val [ENTRIES];
    logic [DATA_W-1:0]  r_rs2_val [ENTRIES];
    logic [OPSEL_W-1:0] r_op_sel  [ENTRIES];
    logic [PC_W-1:0]    r_pc      [ENTRIES];
    logic [DATA_W-1:0]  r_imm     [ENTRIES];
    logic [PC_W-1:0]    r_pred    [ENTRIES];
    // r_age[i][j] set means entry i is older than entry j
    logic [ENTRIES-1:0] r_age     [ENTRIES];
    logic [CNT_W-1:0]   r_cnt;

    // Issue stage registers
    logic               r_is_vld_p1;
    logic               r_is_jal_p1;
    logic               r_is_jalr_p1;
    logic [OPSEL_W-1:0] r_is_op_sel_p1;
    logic [DATA_W-1:0]  r_is_rs1_p1;
    logic [DATA_W-1:0]  r_is_rs2_p1;
    logic [PC_W-1:0]    r_is_pc_p1;
    logic [DATA_W-1:0]  r_is_imm_p1;
    logic [PC_W-1:0]    r_is_pred_p1;

    logic [ENTRIES-1:0] w_cand;
    logic [ENTRIES-1:0] w_blocked;
    logic [ENTRIES-1:0] w_sel_oh;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_sel_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic [ENTRIES-1:0] w_dis_oh;
    logic               w_dis_fire;
    logic               w_dis_rs1_hit;
    logic               w_dis_rs2_hit;
    logic               w_cdb_live;

    assign o_dis_rdy  = (r_cnt != CNT_W'(ENTRIES));
    assign w_dis_fire = i_dis_vld && o_dis_rdy && !i_flush;
    assign w_cdb_live = i_cdb_vld && !i_flush;

    assign w_dis_rs1_hit = !i_dis_rs1_rdy && w_cdb_live && (i_cdb_tag == i_dis_rs1_tag);
    assign w_dis_rs2_hit = !i_dis_rs2_rdy && w_cdb_live && (i_cdb_tag == i_dis_rs2_tag);

    assign w_cand = r_vld & r_rs1_rdy & r_rs2_rdy;

    // An entry is blocked when any older entry is also a candidate
    always_comb begin
        w_blocked = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (r_age[j][i] && w_cand[j]) begin
                    w_blocked[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sel_oh  = w_cand & ~w_blocked;
        w_sel_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_sel_oh[i]) begin
                w_sel_idx = IDX_W'(i);
            end
        end
        w_sel_found = |w_sel_oh;
    end

    // Descending scan so the lowest free index wins
    always_comb begin
        w_free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_vld[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
        w_dis_oh = {{(ENTRIES-1){1'b0}}, 1'b1} << w_free_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_vld       <= '0;
            r_cnt       <= '0;
            r_is_vld_p1 <= 1'b0;
        end else begin
            r_vld       <= (r_vld & ~w_sel_oh) | (w_dis_fire ? w_dis_oh : '0);
            r_is_vld_p1 <= w_sel_found;
            case ({w_dis_fire, w_sel_found})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Entry payload, wakeup and age tracking; validity is gated by r_vld
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_dis_fire && (w_free_idx == IDX_W'(i))) begin
                r_rs1_rdy[i] <= i_dis_rs1_rdy || w_dis_rs1_hit;
                r_rs2_rdy[i] <= i_dis_rs2_rdy || w_dis_rs2_hit;
                r_rs1_tag[i] <= i_dis_rs1_tag;
                r_rs2_tag[i] <= i_dis_rs2_tag;
                r_rs1_val[i] <= w_dis_rs1_hit ? i_cdb_data : i_dis_rs1;
                r_rs2_val[i] <= w_dis_rs2_hit ? i_cdb_data : i_dis_rs2;
                r_jal[i]     <= i_dis_is_jal;
                r_jalr[i]    <= i_dis_is_jalr;
                r_op_sel[i]  <= i_dis_op_sel;
                r_pc[i]      <= i_dis_pc;
                r_imm[i]     <= i_dis_imm;
                r_pred[i]    <= i_dis_pred_jmpaddr;
                r_age[i]     <= '0;
            end else begin
                if (r_vld[i] && !r_rs1_rdy[i] && w_cdb_live && (i_cdb_tag == r_rs1_tag[i])) begin
                    r_rs1_rdy[i] <= 1'b1;
                    r_rs1_val[i] <= i_cdb_data;
                end
                if (r_vld[i] && !r_rs2_rdy[i] && w_cdb_live && (i_cdb_tag == r_rs2_tag[i])) begin
                    r_rs2_rdy[i] <= 1'b1;
                    r_rs2_val[i] <= i_cdb_data;
                end
                if (w_dis_fire && r_vld[i]) begin
                    r_age[i][w_free_idx] <= 1'b1;
                end
            end
        end
    end

    // Issue stage boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_jal_p1    <= 1'b0;
            r_is_jalr_p1   <= 1'b0;
            r_is_op_sel_p1 <= '0;
            r_is_rs1_p1    <= '0;
            r_is_rs2_p1    <= '0;
            r_is_pc_p1     <= '0;
            r_is_imm_p1    <= '0;
            r_is_pred_p1   <= '0;
        end else if (w_sel_found && !i_flush) begin
            r_is_jal_p1    <= r_jal[w_sel_idx];
            r_is_jalr_p1   <= r_jalr[w_sel_idx];
            r_is_op_sel_p1 <= r_op_sel[w_sel_idx];
            r_is_rs1_p1    <= r_rs1_val[w_sel_idx];
            r_is_rs2_p1    <= r_rs2_val[w_sel_idx];
            r_is_pc_p1     <= r_pc[w_sel_idx];
            r_is_imm_p1    <= r_imm[w_sel_idx];
            r_is_pred_p1   <= r_pred[w_sel_idx];
        end
    end

    assign o_is_vld          = r_is_vld_p1;
    assign o_is_jal          = r_is_jal_p1;
    assign o_is_jalr         = r_is_jalr_p1;
    assign o_is_op_sel       = r_is_op_sel_p1;
    assign o_is_rs1          = r_is_rs1_p1;
    assign o_is_rs2          = r_is_rs2_p1;
    assign o_is_pc           = r_is_pc_p1;
    assign o_is_imm          = r_is_imm_p1;
    assign o_is_pred_jmpaddr = r_is_pred_p1;
    assign o_cnt             = r_cnt;

endmodule

// File: tb/tb_br_issue_sched.sv
// Scoreboard bench for br_issue_sched: directed dispatch/wakeup/flush/reset scenarios,
// expected issues queued at stimulus time and checked by an independent monitor.
module tb_br_issue_sched;

    logic        clk;
    logic        rst_n;
    logic        i_flush;
    logic        i_dis_vld;
    logic        o_dis_rdy;
    logic        i_dis_is_jal;
    logic        i_dis_is_jalr;
    logic [3:0]  i_dis_op_sel;
    logic        i_dis_rs1_rdy;
    logic        i_dis_rs2_rdy;
    logic [5:0]  i_dis_rs1_tag;
    logic [5:0]  i_dis_rs2_tag;
    logic [31:0] i_dis_rs1;
    logic [31:0] i_dis_rs2;
    logic [31:0] i_dis_pc;
    logic [31:0] i_dis_imm;
    logic [31:0] i_dis_pred_jmpaddr;
    logic        i_cdb_vld;
    logic [5:0]  i_cdb_tag;
    logic [31:0] i_cdb_data;
    logic        o_is_vld;
    logic        o_is_jal;
    logic        o_is_jalr;
    logic [3:0]  o_is_op_sel;
    logic [31:0] o_is_rs1;
    logic [31:0] o_is_rs2;
    logic [31:0] o_is_pc;
    logic [31:0] o_is_imm;
    logic [31:0] o_is_pred_jmpaddr;
    logic [2:0]  o_cnt;

    br_issue_sched #(.ENTRIES(4), .TAG_W(6), .DATA_W(32), .PC_W(32), .OPSEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
        .i_dis_vld(i_dis_vld), .o_dis_rdy(o_dis_rdy),
        .i_dis_is_jal(i_dis_is_jal), .i_dis_is_jalr(i_dis_is_jalr),
        .i_dis_op_sel(i_dis_op_sel),
        .i_dis_rs1_rdy(i_dis_rs1_rdy), .i_dis_rs2_rdy(i_dis_rs2_rdy),
        .i_dis_rs1_tag(i_dis_rs1_tag), .i_dis_rs2_tag(i_dis_rs2_tag),
        .i_dis_rs1(i_dis_rs1), .i_dis_rs2(i_dis_rs2),
        .i_dis_pc(i_dis_pc), .i_dis_imm(i_dis_imm),
        .i_dis_pred_jmpaddr(i_dis_pred_jmpaddr),
        .i_cdb_vld(i_cdb_vld), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
        .o_is_vld(o_is_vld), .o_is_jal(o_is_jal), .o_is_jalr(o_is_jalr),
        .o_is_op_sel(o_is_op_sel), .o_is_rs1(o_is_rs1), .o_is_rs2(o_is_rs2),
        .o_is_pc(o_is_pc), .o_is_imm(o_is_imm),
        .o_is_pred_jmpaddr(o_is_pred_jmpaddr), .o_cnt(o_cnt)
    );

    typedef struct packed {
        logic        jal;
        logic        jalr;
        logic [3:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] pred;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented issue must match the head of the expected queue
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (o_is_vld) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_issue: got pc=%h rs1=%h rs2=%h at cycle %0d, required no issue",
                         o_is_pc, o_is_rs1, o_is_rs2, cyc);
            end else begin
                e = exp_q.pop_front();
                a = '{o_is_jal, o_is_jalr, o_is_op_sel, o_is_rs1, o_is_rs2,
                      o_is_pc, o_is_imm, o_is_pred_jmpaddr, cyc};
                if (a !== e) begin
                    fails++;
                    $display("FAIL issue_pc_%h: got jal=%b jalr=%b op=%h rs1=%h rs2=%h pc=%h imm=%h pred=%h cyc=%0d, required jal=%b jalr=%b op=%h rs1=%h rs2=%h pc=%h imm=%h pred=%h cyc=%0d",
                             e.pc, a.jal, a.jalr, a.op, a.rs1, a.rs2, a.pc, a.imm, a.pred, a.cyc,
                             e.jal, e.jalr, e.op, e.rs1, e.rs2, e.pc, e.imm, e.pred, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic dis(input logic jal, input logic jalr, input logic [3:0] op,
                       input logic r1rdy, input logic [5:0] r1tag, input logic [31:0] r1,
                       input logic r2rdy, input logic [5:0] r2tag, input logic [31:0] r2,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] pred);
        i_dis_vld = 1'b1;       i_dis_is_jal = jal;     i_dis_is_jalr = jalr;
        i_dis_op_sel = op;
        i_dis_rs1_rdy = r1rdy;  i_dis_rs1_tag = r1tag;  i_dis_rs1 = r1;
        i_dis_rs2_rdy = r2rdy;  i_dis_rs2_tag = r2tag;  i_dis_rs2 = r2;
        i_dis_pc = pc;          i_dis_imm = imm;        i_dis_pred_jmpaddr = pred;
    endtask

    task automatic expect_issue(input logic jal, input logic jalr, input logic [3:0] op,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] pred, input int at_cyc);
        exp_t e;
        e = '{jal, jalr, op, r1, r2, pc, imm, pred, at_cyc};
        exp_q.push_back(e);
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
        i_cdb_vld = 1'b1;
        i_cdb_tag = tag;
        i_cdb_data = data;
    endtask

    task automatic idle();
        i_dis_vld = 1'b0;
        i_cdb_vld = 1'b0;
        i_flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        i_flush = 1'b0; i_dis_vld = 1'b0; i_dis_is_jal = 1'b0; i_dis_is_jalr = 1'b0;
        i_dis_op_sel = '0; i_dis_rs1_rdy = 1'b0; i_dis_rs2_rdy = 1'b0;
        i_dis_rs1_tag = '0; i_dis_rs2_tag = '0; i_dis_rs1 = '0; i_dis_rs2 = '0;
        i_dis_pc = '0; i_dis_imm = '0; i_dis_pred_jmpaddr = '0;
        i_cdb_vld = 1'b0; i_cdb_tag = '0; i_cdb_data = '0;

        // Reset state
        step(); step();
        chk("rst_dis_rdy", 32'(o_dis_rdy), 32'd1);
        chk("rst_is_vld", 32'(o_is_vld), 32'd0);
        chk("rst_cnt", 32'(o_cnt), 32'd0);
        chk("rst_is_pc", o_is_pc, 32'd0);
        rst_n = 1'b1;
        step();

        // Single JAL with ready operands issues two edges after being driven
        dis(1'b1, 1'b0, 4'h0, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2, 32'h100, 32'h20, 32'h120);
        expect_issue(1'b1, 1'b0, 4'h0, 32'h1, 32'h2, 32'h100, 32'h20, 32'h120, cyc + 2);
        step(); idle();
        chk("t1_cnt_after_dis", 32'(o_cnt), 32'd1);
        step();
        chk("t1_cnt_after_issue", 32'(o_cnt), 32'd0);
        step(); step();

        // Waiting A is overtaken by ready B; A issues after its CDB wakeup
        dis(1'b0, 1'b0, 4'h1, 1'b0, 6'd5, 32'h0, 1'b1, 6'd0, 32'hA2, 32'h200, 32'h8, 32'h208);
        step();
        dis(1'b0, 1'b1, 4'h2, 1'b1, 6'd0, 32'hB1, 1'b1, 6'd0, 32'hB2, 32'h210, 32'hC, 32'h21C);
        expect_issue(1'b0, 1'b1, 4'h2, 32'hB1, 32'hB2, 32'h210, 32'hC, 32'h21C, cyc + 2);
        step(); idle();
        step();
        cdb(6'd5, 32'hDEAD);
        expect_issue(1'b0, 1'b0, 4'h1, 32'hDEAD, 32'hA2, 32'h200, 32'h8, 32'h208, cyc + 2);
        step(); idle();
        step(); step();
        chk("t2_cnt_drained", 32'(o_cnt), 32'd0);

        // Fill all four entries on tag 9, then drain in dispatch order
        for (int k = 0; k < 4; k++) begin
            dis(1'b0, 1'b0, 4'(k), 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'h30 + 32'(k),
                32'h300 + 32'(4 * k), 32'h40, 32'h340);
            step();
        end
        idle();
        chk("t3_full_dis_rdy", 32'(o_dis_rdy), 32'd0);
        chk("t3_full_cnt", 32'(o_cnt), 32'd4);
        cdb(6'd9, 32'h99);
        for (int k = 0; k < 4; k++) begin
            expect_issue(1'b0, 1'b0, 4'(k), 32'h99, 32'h30 + 32'(k),
                         32'h300 + 32'(4 * k), 32'h40, 32'h340, cyc + 2 + k);
        end
        step(); idle();
        // Dispatch attempt while full must be dropped
        dis(1'b1, 1'b0, 4'hF, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 32'hBAD, 32'h0, 32'h0);
        chk("t3_still_full_rdy", 32'(o_dis_rdy), 32'd0);
        step(); idle();
        chk("t3_rdy_after_first_issue", 32'(o_dis_rdy), 32'd1);
        chk("t3_cnt_after_first_issue", 32'(o_cnt), 32'd3);
        step(); step(); step();
        chk("t3_cnt_drained", 32'(o_cnt), 32'd0);
        step();

        // Dispatch-cycle CDB bypass on rs2
        dis(1'b0, 1'b0, 4'h5, 1'b1, 6'd0, 32'h11, 1'b0, 6'd3, 32'h0, 32'h400, 32'h4, 32'h404);
        cdb(6'd3, 32'h7);
        expect_issue(1'b0, 1'b0, 4'h5, 32'h11, 32'h7, 32'h400, 32'h4, 32'h404, cyc + 2);
        step(); idle();
        step(); step();

        // Flush with a ready entry about to issue, a concurrent dispatch and a CDB
        dis(1'b0, 1'b0, 4'h1, 1'b0, 6'd12, 32'h0, 1'b1, 6'd0, 32'h1, 32'h500, 32'h0, 32'h0);
        step();
        dis(1'b0, 1'b0, 4'h1, 1'b1, 6'd0, 32'h1, 1'b0, 6'd12, 32'h0, 32'h504, 32'h0, 32'h0);
        step();
        dis(1'b1, 1'b0, 4'h0, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2, 32'h508, 32'h0, 32'h0);
        step();
        chk("t5_cnt_before_flush", 32'(o_cnt), 32'd3);
        dis(1'b1, 1'b0, 4'h0, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2, 32'h5FF, 32'h0, 32'h0);
        cdb(6'd12, 32'h12);
        i_flush = 1'b1;
        step(); idle();
        chk("t5_cnt_after_flush", 32'(o_cnt), 32'd0);
        chk("t5_is_vld_after_flush", 32'(o_is_vld), 32'd0);
        chk("t5_dis_rdy_after_flush", 32'(o_dis_rdy), 32'd1);
        cdb(6'd12, 32'h12);
        step(); idle();
        step(); step(); step();

        // Reset mid-stream with two entries pending
        dis(1'b0, 1'b0, 4'h3, 1'b0, 6'd20, 32'h0, 1'b1, 6'd0, 32'h1, 32'h600, 32'h0, 32'h0);
        step();
        dis(1'b0, 1'b0, 4'h3, 1'b0, 6'd20, 32'h0, 1'b1, 6'd0, 32'h1, 32'h604, 32'h0, 32'h0);
        step(); idle();
        chk("t6_cnt_before_reset", 32'(o_cnt), 32'd2);
        rst_n = 1'b0;
        step();
        chk("t6_rst_cnt", 32'(o_cnt), 32'd0);
        chk("t6_rst_is_vld", 32'(o_is_vld), 32'd0);
        chk("t6_rst_dis_rdy", 32'(o_dis_rdy), 32'd1);
        chk("t6_rst_is_pc", o_is_pc, 32'd0);
        chk("t6_rst_is_rs2", o_is_rs2, 32'd0);
        rst_n = 1'b1;
        cdb(6'd20, 32'h20);
        step(); idle();
        step(); step(); step();
        chk("t6_cnt_after_release", 32'(o_cnt), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
